// File: rtl/matrix_skew_feeder_if.sv
// Load/start bus plus the skewed A/B streams and control strobes of the
// matrix skew feeder.
interface matrix_skew_feeder_if #(
  parameter int DW = 32
);
  logic          load_valid;
  logic          load_sel;
  logic [3:0]    load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic [DW-1:0] A1, A2, A3, A4;
  logic [DW-1:0] B1, B2, B3, B4;
  logic          mult_en;
  logic          add_en;
  logic          out_en;
  logic          busy;
  logic          done;
  logic          load_err;

  modport master (
    output load_valid, load_sel, load_addr, load_data, start,
    input  A1, A2, A3, A4, B1, B2, B3, B4,
    input  mult_en, add_en, out_en, busy, done, load_err
  );

  modport slave (
    input  load_valid, load_sel, load_addr, load_data, start,
    output A1, A2, A3, A4, B1, B2, B3, B4,
    output mult_en, add_en, out_en, busy, done, load_err
  );
endinterface

// File: rtl/matrix_skew_feeder.sv
// Feeds two 4x4 banks into a systolic multiplier as row-skewed A and
// column-skewed B streams over a 10-step FEED window, then one OUT cycle.
module matrix_skew_feeder #(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_skew_feeder_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd9;

  state_t        state_r, state_s;
  logic [3:0]    cnt_r, cnt_s;
  logic          busy_r;
  logic          accept_s;
  logic [1:0]    row_s, col_s;
  logic [DW-1:0] bank_a_r [4][4];
  logic [DW-1:0] bank_b_r [4][4];
  logic [DW-1:0] a_n_s [4][4];
  logic [DW-1:0] b_n_s [4][4];
  logic [DW-1:0] a_out_s [4];
  logic [DW-1:0] b_out_s [4];
  logic [3:0]    diag_s [4];

  assign accept_s = bus.load_valid && !busy_r;
  assign row_s    = bus.load_addr[3:2];
  assign col_s    = bus.load_addr[1:0];
  assign bus.busy = busy_r;

  // Bank contents as of the coming edge, so a load coinciding with start is seen by step 0
  always_comb begin
    a_n_s = bank_a_r;
    b_n_s = bank_b_r;
    if (accept_s) begin
      if (bus.load_sel) begin
        b_n_s[row_s][col_s] = bus.load_data;
      end else begin
        a_n_s[row_s][col_s] = bus.load_data;
      end
    end else begin
      a_n_s = bank_a_r;
      b_n_s = bank_b_r;
    end
  end

  // Sequencer next state and step counter
  always_comb begin
    state_s = state_r;
    cnt_s   = 4'd0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_FEED;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (cnt_r == LAST_STEP) begin
          state_s = ST_OUT;
        end else begin
          state_s = ST_FEED;
          cnt_s   = cnt_r + 4'd1;
        end
      end
      ST_OUT:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Stream i carries A row i / B column i delayed by i steps
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      diag_s[i]  = cnt_s - 4'(i);
      a_out_s[i] = '0;
      b_out_s[i] = '0;
      if ((state_s == ST_FEED) && (cnt_s >= 4'(i)) && (diag_s[i] <= 4'd3)) begin
        a_out_s[i] = a_n_s[i][diag_s[i][1:0]];
        b_out_s[i] = b_n_s[diag_s[i][1:0]][i];
      end else begin
        a_out_s[i] = '0;
        b_out_s[i] = '0;
      end
    end
  end

  // State, banks and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      busy_r       <= 1'b0;
      bank_a_r     <= '{default: '0};
      bank_b_r     <= '{default: '0};
      bus.A1       <= '0;
      bus.A2       <= '0;
      bus.A3       <= '0;
      bus.A4       <= '0;
      bus.B1       <= '0;
      bus.B2       <= '0;
      bus.B3       <= '0;
      bus.B4       <= '0;
      bus.mult_en  <= 1'b0;
      bus.add_en   <= 1'b0;
      bus.out_en   <= 1'b0;
      bus.done     <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      busy_r       <= (state_s != ST_IDLE);
      bank_a_r     <= a_n_s;
      bank_b_r     <= b_n_s;
      bus.A1       <= a_out_s[0];
      bus.A2       <= a_out_s[1];
      bus.A3       <= a_out_s[2];
      bus.A4       <= a_out_s[3];
      bus.B1       <= b_out_s[0];
      bus.B2       <= b_out_s[1];
      bus.B3       <= b_out_s[2];
      bus.B4       <= b_out_s[3];
      bus.mult_en  <= (state_s == ST_FEED);
      bus.add_en   <= (state_s == ST_FEED);
      bus.out_en   <= (state_s == ST_OUT);
      bus.done     <= (state_r == ST_OUT);
      bus.load_err <= bus.load_valid && busy_r;
    end
  end
endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Randomized bench for matrix_skew_feeder against a timeline model: a start
// accepted at edge N defines cycle N+k, k=1..10 FEED, 11 OUT, 12 done.
module tb_matrix_skew_feeder;
  localparam int DW = 32;
  localparam int PW = 8 * DW + 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  matrix_skew_feeder_if #(.DW(DW)) bus ();

  matrix_skew_feeder #(.DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model
  int            m_k = 0;
  logic [DW-1:0] ref_a [4][4];
  logic [DW-1:0] ref_b [4][4];
  logic [DW-1:0] e_a [4];
  logic [DW-1:0] e_b [4];
  logic          e_mult, e_out, e_busy, e_done, e_err;

  function automatic logic [DW-1:0] obs_a(input int i);
    case (i)
      0: return bus.A1;
      1: return bus.A2;
      2: return bus.A3;
      default: return bus.A4;
    endcase
  endfunction

  function automatic logic [DW-1:0] obs_b(input int i);
    case (i)
      0: return bus.B1;
      1: return bus.B2;
      2: return bus.B3;
      default: return bus.B4;
    endcase
  endfunction

  function automatic logic [PW-1:0] pack_obs();
    return {bus.A1, bus.A2, bus.A3, bus.A4, bus.B1, bus.B2, bus.B3, bus.B4,
            bus.mult_en, bus.add_en, bus.out_en, bus.busy, bus.done, bus.load_err};
  endfunction

  function automatic logic [PW-1:0] pack_exp();
    return {e_a[0], e_a[1], e_a[2], e_a[3], e_b[0], e_b[1], e_b[2], e_b[3],
            e_mult, e_mult, e_out, e_busy, e_done, e_err};
  endfunction

  task automatic model_edge();
    bit busy_pre;
    int t;
    busy_pre = (m_k >= 1) && (m_k <= 11);
    if (reset) begin
      m_k   = 0;
      e_err = 1'b0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          ref_a[r][c] = '0;
          ref_b[r][c] = '0;
        end
    end else begin
      e_err = bus.load_valid && busy_pre;
      if (bus.load_valid && !busy_pre) begin
        if (bus.load_sel) ref_b[bus.load_addr[3:2]][bus.load_addr[1:0]] = bus.load_data;
        else              ref_a[bus.load_addr[3:2]][bus.load_addr[1:0]] = bus.load_data;
      end
      if (busy_pre)       m_k = m_k + 1;
      else if (bus.start) m_k = 1;
      else                m_k = 0;
    end
    t = m_k - 1;
    for (int i = 0; i < 4; i++) begin
      e_a[i] = '0;
      e_b[i] = '0;
      if (m_k >= 1 && m_k <= 10 && t - i >= 0 && t - i <= 3) begin
        e_a[i] = ref_a[i][t - i];
        e_b[i] = ref_b[t - i][i];
      end
    end
    e_mult = (m_k >= 1) && (m_k <= 10);
    e_out  = (m_k == 11);
    e_busy = (m_k >= 1) && (m_k <= 11);
    e_done = (m_k == 12);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
  endtask

  task automatic do_load(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    bus.load_valid = 1'b1;
    bus.load_sel   = sel;
    bus.load_addr  = addr;
    bus.load_data  = data;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_sel   = 1'b0;
    bus.load_addr  = 4'd0;
    bus.load_data  = 32'h1234_5678;
    bus.start      = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    if (pack_obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", pack_obs());
    end
    tick();
    reset = 1'b0;
    do_load(1'b0, 4'd5, 32'hA5A5_0001);
    bus.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (pack_obs() !== pack_exp()) begin
        miscompares++;
        $display("FAIL post_reset k=%0d got %h want %h", k, pack_obs(), pack_exp());
      end
    end
  endtask

  task automatic test_identity();
    longint hist_a [10][4];
    longint hist_b [10][4];
    longint acc;
    bit     c_ok;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        do_load(1'b0, 4'(4 * r + c), (r == c) ? 32'd1 : 32'd0);
        do_load(1'b1, 4'(4 * r + c), 32'(4 * r + c + 1));
      end
    bus.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (pack_obs() !== pack_exp()) begin
        miscompares++;
        $display("FAIL identity_model k=%0d got %h want %h", k, pack_obs(), pack_exp());
      end
      if (k <= 10)
        for (int i = 0; i < 4; i++) begin
          hist_a[k - 1][i] = longint'(obs_a(i));
          hist_b[k - 1][i] = longint'(obs_b(i));
        end
      if (k == 1) begin
        vectors++;
        if (bus.A1 !== 32'd1 || bus.B1 !== 32'd1 || bus.A2 !== 32'd0 || bus.B2 !== 32'd0 ||
            bus.A4 !== 32'd0 || bus.B4 !== 32'd0) begin
          miscompares++;
          $display("FAIL identity_first A1=%0d B1=%0d A2=%0d B2=%0d want 1 1 0 0", bus.A1, bus.B1, bus.A2, bus.B2);
        end
      end
      if (k == 4) begin
        vectors++;
        if (bus.B4 !== 32'd4 || bus.A1 !== 32'd0 || bus.A2 !== 32'd0 || bus.A3 !== 32'd0) begin
          miscompares++;
          $display("FAIL identity_t3 B4=%0d A1=%0d A2=%0d A3=%0d want 4 0 0 0", bus.B4, bus.A1, bus.A2, bus.A3);
        end
      end
      if (k == 7) begin
        vectors++;
        if (bus.A4 !== 32'd1) begin
          miscompares++;
          $display("FAIL identity_t6 A4=%0d want 1", bus.A4);
        end
      end
      if (k == 11) begin
        vectors++;
        if (bus.out_en !== 1'b1 || bus.mult_en !== 1'b0) begin
          miscompares++;
          $display("FAIL identity_out out_en=%b mult_en=%b want 1 0", bus.out_en, bus.mult_en);
        end
      end
      if (k == 12) begin
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL identity_done done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
      end
    end
    // output-stationary array: PE(i,j) sees A row i delayed by j and B column j delayed by i
    c_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int s = 0; s < 10; s++)
          if (s - j >= 0 && s - i >= 0) acc += hist_a[s - j][i] * hist_b[s - i][j];
        if (acc != longint'(4 * i + j + 1)) c_ok = 1'b0;
      end
    vectors++;
    if (!c_ok) begin
      miscompares++;
      $display("FAIL identity_product got C!=B want C==B");
    end
  endtask

  task automatic test_skew();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        do_load(1'b0, 4'(4 * r + c), 32'(16 * r + c));
        do_load(1'b1, 4'(4 * r + c), 32'd0);
      end
    bus.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (pack_obs() !== pack_exp()) begin
        miscompares++;
        $display("FAIL skew_model k=%0d got %h want %h", k, pack_obs(), pack_exp());
      end
      if (k == 4) begin
        vectors++;
        if (bus.A1 !== 32'd3 || bus.A2 !== 32'd18 || bus.A3 !== 32'd33 || bus.A4 !== 32'd48) begin
          miscompares++;
          $display("FAIL skew_t3 A=%0d,%0d,%0d,%0d want 3,18,33,48", bus.A1, bus.A2, bus.A3, bus.A4);
        end
      end
      if (k == 7) begin
        vectors++;
        if (bus.A1 !== 32'd0 || bus.A2 !== 32'd0 || bus.A3 !== 32'd0 || bus.A4 !== 32'd51) begin
          miscompares++;
          $display("FAIL skew_t6 A=%0d,%0d,%0d,%0d want 0,0,0,51", bus.A1, bus.A2, bus.A3, bus.A4);
        end
      end
      if (k >= 8 && k <= 10) begin
        vectors++;
        if ({bus.A1, bus.A2, bus.A3, bus.A4} !== '0 || bus.mult_en !== 1'b1) begin
          miscompares++;
          $display("FAIL skew_drain k=%0d A=%h mult_en=%b want 0 1", k, {bus.A1, bus.A2, bus.A3, bus.A4}, bus.mult_en);
        end
      end
    end
  endtask

  task automatic test_busy_load();
    logic [PW-1:0] rec [12];
    bit            same;
    for (int n = 0; n < 32; n++) do_load(n[0], n[4:1], $urandom);
    for (int run = 0; run < 2; run++) begin
      same = 1'b1;
      bus.start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        tick();
        vectors++;
        if (pack_obs() !== pack_exp()) begin
          miscompares++;
          $display("FAIL busy_load_model run=%0d k=%0d got %h want %h", run, k, pack_obs(), pack_exp());
        end
        if (k == 7) begin
          vectors++;
          if (bus.load_err !== (run == 0)) begin
            miscompares++;
            $display("FAIL busy_load_err run=%0d got %b want %b", run, bus.load_err, run == 0);
          end
        end
        if (run == 0) rec[k - 1] = pack_obs() & ~{{(PW - 1){1'b0}}, 1'b1};
        else if ((pack_obs() & ~{{(PW - 1){1'b0}}, 1'b1}) !== rec[k - 1]) same = 1'b0;
        if (run == 0 && k == 6) begin
          bus.load_valid = 1'b1;
          bus.load_sel   = 1'b0;
          bus.load_addr  = 4'd0;
          bus.load_data  = 32'hDEAD_BEEF;
        end
      end
    end
    vectors++;
    if (!same) begin
      miscompares++;
      $display("FAIL busy_load_rerun got differing outputs want identical");
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int out_at = -1;
    bus.start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++;
      if (pack_obs() !== pack_exp()) begin
        miscompares++;
        $display("FAIL start_ignored_model k=%0d got %h want %h", k, pack_obs(), pack_exp());
      end
      if (bus.done === 1'b1) dones++;
      if (bus.out_en === 1'b1) out_at = k;
      if (k == 3 || k == 11) bus.start = 1'b1;
    end
    vectors++;
    if (dones != 1 || out_at != 11) begin
      miscompares++;
      $display("FAIL start_ignored dones=%0d out_at=%0d want 1 11", dones, out_at);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int nonzero = 0;
    for (int n = 0; n < 8; n++) do_load(n[0], 4'($urandom_range(0, 15)), $urandom | 32'h1);
    bus.start = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (pack_obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got %h want 0", pack_obs());
    end
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.out_en === 1'b1 || bus.load_err === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL reset_mid_pulses got %0d want 0", dones);
    end
    bus.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (pack_obs() !== pack_exp()) begin
        miscompares++;
        $display("FAIL reset_mid_model k=%0d got %h want %h", k, pack_obs(), pack_exp());
      end
      for (int i = 0; i < 4; i++) if (obs_a(i) !== 32'd0 || obs_b(i) !== 32'd0) nonzero++;
    end
    vectors++;
    if (nonzero != 0) begin
      miscompares++;
      $display("FAIL reset_mid_zero_banks got %0d nonzero want 0", nonzero);
    end
  endtask

  task automatic test_back_to_back();
    int idle_cycles = 0;
    logic [DW-1:0] v;
    v = $urandom | 32'h1;
    bus.load_valid = 1'b1;
    bus.load_sel   = 1'b0;
    bus.load_addr  = 4'd0;
    bus.load_data  = v;
    bus.start      = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      vectors++;
      if (pack_obs() !== pack_exp()) begin
        miscompares++;
        $display("FAIL back_to_back_model k=%0d got %h want %h", k, pack_obs(), pack_exp());
      end
      if (k == 1) begin
        vectors++;
        if (bus.A1 !== v) begin
          miscompares++;
          $display("FAIL load_with_start A1=%h want %h", bus.A1, v);
        end
      end
      if (k <= 23 && bus.busy !== 1'b1) idle_cycles++;
      if (k == 12) bus.start = 1'b1;
    end
    vectors++;
    if (idle_cycles != 1) begin
      miscompares++;
      $display("FAIL back_to_back_gaps got %0d want 1", idle_cycles);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      for (int n = 0; n < 6; n++) do_load($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom);
      bus.start = 1'b1;
      for (int k = 1; k <= 13; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.load_valid = 1'b1;
          bus.load_sel   = 1'($urandom_range(0, 1));
          bus.load_addr  = 4'($urandom_range(0, 15));
          bus.load_data  = $urandom;
        end
        tick();
        vectors++;
        if (pack_obs() !== pack_exp()) begin
          miscompares++;
          $display("FAIL random run=%0d k=%0d got %h want %h", run, k, pack_obs(), pack_exp());
        end
      end
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_sel   = 1'b0;
    bus.load_addr  = 4'd0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    test_reset();
    test_identity();
    test_skew();
    test_busy_load();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
